// File: rtl/bundle_packer_if.sv
// rtl/bundle_packer_if.sv - opcode stream and closed-bundle handshake between issue source, packer and decoder
interface bundle_packer_if;
    logic       op_valid;
    logic       op_ready;
    logic [4:0] op_code;
    logic       flush;
    logic       bnd_valid;
    logic       bnd_ready;
    logic [4:0] bnd_a0;
    logic [4:0] bnd_a1;
    logic [4:0] bnd_m;
    logic [4:0] bnd_ls;
    logic [3:0] bnd_mask;
    logic       illegal;

    modport master (
        output op_valid, op_code, flush, bnd_ready,
        input  op_ready, bnd_valid, bnd_a0, bnd_a1, bnd_m, bnd_ls, bnd_mask, illegal
    );

    modport slave (
        input  op_valid, op_code, flush, bnd_ready,
        output op_ready, bnd_valid, bnd_a0, bnd_a1, bnd_m, bnd_ls, bnd_mask, illegal
    );
endinterface

// File: rtl/bundle_packer.sv
// rtl/bundle_packer.sv - packs serial 5-bit opcodes into {A0,A1,M,LS} bundles; BUNDLE_TIMEOUT_EN adds forced close after MAX_WAIT
module bundle_packer #(
`ifdef BUNDLE_TIMEOUT_EN
    parameter int         MAX_WAIT = 8,
`endif
    parameter logic [4:0] NOP_ALU  = 5'b00000,
    parameter logic [4:0] NOP_M    = 5'b01100,
    parameter logic [4:0] NOP_LS   = 5'b11111
) (
    input  logic            clk,
    input  logic            rst_n,
    bundle_packer_if.slave  bus
);
    typedef enum logic [1:0] {EMPTY, FILL, FULL} state_t;

    state_t     state, state_nxt;
    logic [4:0] a0_q, a1_q, m_q, ls_q;
    logic [4:0] a0_nxt, a1_nxt, m_nxt, ls_nxt;
    logic [3:0] mask_q, mask_nxt;
    logic       illegal_q;

    logic is_alu, is_m, is_ls, legal, conflict, timeout_hit, accept;

    assign is_alu = (bus.op_code <= 5'b01011);
    assign is_m   = (bus.op_code >= 5'b01100) && (bus.op_code <= 5'b01110);
    assign is_ls  = (bus.op_code == 5'b10000) || (bus.op_code == 5'b10001);
    assign legal  = is_alu || is_m || is_ls;

    // An ALU op only conflicts once both ALU slots are taken
    assign conflict = legal && ((is_alu && mask_q[3] && mask_q[2]) ||
                                (is_m && mask_q[1]) || (is_ls && mask_q[0]));

`ifdef BUNDLE_TIMEOUT_EN
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] cnt;

    assign timeout_hit = (state == FILL) && (cnt == CW'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == EMPTY || (state == FULL && bus.bnd_ready)) begin
            cnt <= '0;
        end else if (state == FILL && cnt != CW'(MAX_WAIT)) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign bus.op_ready = (state != FULL) && !bus.flush && !conflict && !timeout_hit;
    assign accept       = bus.op_valid && bus.op_ready;

    always_comb begin
        state_nxt = state;
        a0_nxt    = a0_q;
        a1_nxt    = a1_q;
        m_nxt     = m_q;
        ls_nxt    = ls_q;
        mask_nxt  = mask_q;
        if (accept && legal) begin
            if (is_alu) begin
                if (!mask_q[3]) begin
                    a0_nxt      = bus.op_code;
                    mask_nxt[3] = 1'b1;
                end else begin
                    a1_nxt      = bus.op_code;
                    mask_nxt[2] = 1'b1;
                end
            end else if (is_m) begin
                m_nxt       = bus.op_code;
                mask_nxt[1] = 1'b1;
            end else begin
                ls_nxt      = bus.op_code;
                mask_nxt[0] = 1'b1;
            end
        end
        case (state)
            EMPTY: begin
                if (accept && legal) state_nxt = FILL;
            end
            FILL: begin
                if (mask_nxt == 4'b1111 || bus.flush || timeout_hit ||
                    (bus.op_valid && conflict)) state_nxt = FULL;
            end
            FULL: begin
                if (bus.bnd_ready) begin
                    state_nxt = EMPTY;
                    a0_nxt    = NOP_ALU;
                    a1_nxt    = NOP_ALU;
                    m_nxt     = NOP_M;
                    ls_nxt    = NOP_LS;
                    mask_nxt  = 4'b0000;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            a0_q      <= NOP_ALU;
            a1_q      <= NOP_ALU;
            m_q       <= NOP_M;
            ls_q      <= NOP_LS;
            mask_q    <= 4'b0000;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            a0_q      <= a0_nxt;
            a1_q      <= a1_nxt;
            m_q       <= m_nxt;
            ls_q      <= ls_nxt;
            mask_q    <= mask_nxt;
            illegal_q <= accept && !legal;
        end
    end

    assign bus.bnd_valid = (state == FULL);
    assign bus.bnd_a0    = a0_q;
    assign bus.bnd_a1    = a1_q;
    assign bus.bnd_m     = m_q;
    assign bus.bnd_ls    = ls_q;
    assign bus.bnd_mask  = mask_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_bundle_packer.sv
// tb/tb_bundle_packer.sv - scoreboard bench for bundle_packer with directed opcode vectors
module tb_bundle_packer;
    typedef struct packed {
        logic [4:0] a0;
        logic [4:0] a1;
        logic [4:0] m;
        logic [4:0] ls;
        logic [3:0] mask;
    } bnd_t;

    logic clk;
    logic rst_n;
    bundle_packer_if bif();

    bundle_packer dut (.clk(clk), .rst_n(rst_n), .bus(bif));

    int   vectors     = 0;
    int   miscompares = 0;
    bnd_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_bnd(input logic [4:0] a0, input logic [4:0] a1,
                              input logic [4:0] m, input logic [4:0] ls, input logic [3:0] mask);
        bnd_t e;
        e = '{a0: a0, a1: a1, m: m, ls: ls, mask: mask};
        exp_q.push_back(e);
    endtask

    // Monitor: every handshake must match the next expected bundle
    initial begin
        bnd_t got, e;
        forever begin
            @(negedge clk);
            if (rst_n && bif.bnd_valid && bif.bnd_ready) begin
                got = '{a0: bif.bnd_a0, a1: bif.bnd_a1, m: bif.bnd_m, ls: bif.bnd_ls, mask: bif.bnd_mask};
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL bundle_unexpected: got %h expected none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        miscompares++;
                        $display("FAIL bundle: got %h expected %h", got, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic seen;
        rst_n = 1'b0;
        bif.op_valid = 1'b0; bif.op_code = 5'd0; bif.flush = 1'b0; bif.bnd_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        check("rst_valid", bif.bnd_valid, 1'b0);
        check("rst_mask", bif.bnd_mask, 4'b0000);
        check("rst_slots", {bif.bnd_a0, bif.bnd_a1, bif.bnd_m, bif.bnd_ls}, {5'h00, 5'h00, 5'h0C, 5'h1F});
        check("rst_illegal", bif.illegal, 1'b0);
        check("rst_ready", bif.op_ready, 1'b1);

        // T1: full bundle on consecutive cycles
        bif.bnd_ready = 1'b1;
        expect_bnd(5'b00001, 5'b00010, 5'b01101, 5'b10001, 4'b1111);
        bif.op_valid = 1'b1; bif.op_code = 5'b00001; tick();
        bif.op_code = 5'b00010; tick();
        bif.op_code = 5'b01101; tick();
        bif.op_code = 5'b10001; #1;
        check("t1_ready4", bif.op_ready, 1'b1);
        tick();
        bif.op_valid = 1'b0;
        check("t1_latency", bif.bnd_valid, 1'b1);
        tick();
        check("t1_drained", bif.bnd_valid, 1'b0);

        // T2: third ALU op conflicts and stalls until handshake
        bif.bnd_ready = 1'b0;
        expect_bnd(5'b00011, 5'b00011, 5'b01100, 5'b11111, 4'b1100);
        bif.op_valid = 1'b1; bif.op_code = 5'b00011; tick();
        tick();
        #1;
        check("t2_conflict_ready", bif.op_ready, 1'b0);
        tick();
        check("t2_closed", bif.bnd_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("t2_stall_ready", bif.op_ready, 1'b0);
            check("t2_hold", {bif.bnd_valid, bif.bnd_mask, bif.bnd_a1}, {1'b1, 4'b1100, 5'b00011});
            tick();
        end
        bif.bnd_ready = 1'b1;
        tick();
        check("t2_empty_ready", bif.op_ready, 1'b1);
        tick();
        bif.op_valid = 1'b0;
        check("t2_next_a0", {bif.bnd_mask, bif.bnd_a0}, {4'b1000, 5'b00011});
        expect_bnd(5'b00011, 5'b00000, 5'b01100, 5'b11111, 4'b1000);
        bif.flush = 1'b1; tick();
        bif.flush = 1'b0;
        check("t2_flush_close", bif.bnd_valid, 1'b1);
        tick();

        // T3: flush beats a concurrent op
        bif.bnd_ready = 1'b0;
        expect_bnd(5'b00000, 5'b00000, 5'b01100, 5'b10000, 4'b0001);
        bif.op_valid = 1'b1; bif.op_code = 5'b10000; tick();
        bif.op_code = 5'b01110; bif.flush = 1'b1; #1;
        check("t3_flush_blocks", bif.op_ready, 1'b0);
        tick();
        bif.flush = 1'b0;
        check("t3_mask", bif.bnd_mask, 4'b0001);
        bif.bnd_ready = 1'b1;
        tick();
        tick();
        bif.op_valid = 1'b0;
        check("t3_m_next", {bif.bnd_mask, bif.bnd_m}, {4'b0010, 5'b01110});
        expect_bnd(5'b00000, 5'b00000, 5'b01110, 5'b11111, 4'b0010);
        bif.flush = 1'b1; tick();
        bif.flush = 1'b0; tick();

        // T4: illegal op dropped with a one-cycle pulse; flush in EMPTY ignored
        bif.op_valid = 1'b1; bif.op_code = 5'b10101; #1;
        check("t4_ready", bif.op_ready, 1'b1);
        tick();
        bif.op_valid = 1'b0;
        check("t4_pulse", {bif.illegal, bif.bnd_valid, bif.bnd_mask}, {1'b1, 1'b0, 4'b0000});
        bif.flush = 1'b1; tick();
        bif.flush = 1'b0;
        check("t4_pulse_end", bif.illegal, 1'b0);
        check("t4_flush_empty", bif.bnd_valid, 1'b0);

        // T5: lone op with idle afterwards
        bif.op_valid = 1'b1; bif.op_code = 5'b01100; tick();
        bif.op_valid = 1'b0;
        expect_bnd(5'b00000, 5'b00000, 5'b01100, 5'b11111, 4'b0010);
`ifdef BUNDLE_TIMEOUT_EN
        n = 0; seen = 1'b0;
        while (!seen && n < 30) begin
            tick(); n++;
            seen = bif.bnd_valid;
        end
        check("t5_timeout_cycles", n, 9);
        tick();
`else
        seen = 1'b0;
        n = 0;
        repeat (100) begin
            tick(); n++;
            if (bif.bnd_valid) seen = 1'b1;
        end
        check("t5_no_timeout", seen, 1'b0);
        bif.flush = 1'b1; tick();
        bif.flush = 1'b0; tick();
`endif

        // T6: reset while FULL discards the bundle
        bif.bnd_ready = 1'b0;
        bif.op_valid = 1'b1; bif.op_code = 5'b00001; tick();
        bif.op_valid = 1'b0; bif.flush = 1'b1; tick();
        bif.flush = 1'b0;
        check("t6_full", bif.bnd_valid, 1'b1);
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        check("t6_reset", {bif.bnd_valid, bif.bnd_mask, bif.bnd_a0, bif.bnd_a1, bif.bnd_m, bif.bnd_ls},
              {1'b0, 4'b0000, 5'h00, 5'h00, 5'h0C, 5'h1F});
        bif.bnd_ready = 1'b1;
        repeat (3) tick();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
